alu_lockstep_checker: RTL and testbench

//  Two parametrised ALU lanes with a registered result stage, bitwise result/carry comparator,

---
 rtl/alu_lockstep_checker_pkg.sv | 15 +
 rtl/alu_lockstep_checker_lane.sv | 48 ++++
 rtl/alu_lockstep_checker.sv | 146 ++++++++++++++
 tb/tb_alu_lockstep_checker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_lockstep_checker_pkg.sv
// Opcode encodings shared by the ALU lanes and the lockstep checker top.
package alu_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
   localparam logic [OP_W-1:0] OP_AND  = 3'b010;
   localparam logic [OP_W-1:0] OP_OR   = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
   localparam logic [OP_W-1:0] OP_SHL1 = 3'b101;
   localparam logic [OP_W-1:0] OP_SHR1 = 3'b110;
   localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/alu_lockstep_checker_lane.sv
// Single combinational ALU lane: result plus carry/borrow/shifted-out bit.
module alu_lane
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [OP_W-1:0]  sel_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o
);

   logic [WIDTH:0] wide;

   // Opcode decode; carry is the extra bit of the widened add/sub or the bit shifted out.
   always_comb begin
      wide     = '0;
      result_o = '0;
      carry_o  = 1'b0;
      case (sel_i)
         OP_ADD: begin
            wide     = {1'b0, a_i} + {1'b0, b_i};
            result_o = wide[WIDTH-1:0];
            carry_o  = wide[WIDTH];
         end
         OP_SUB: begin
            wide     = {1'b0, a_i} - {1'b0, b_i};
            result_o = wide[WIDTH-1:0];
            carry_o  = wide[WIDTH];
         end
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_SHL1: begin
            result_o = {a_i[WIDTH-2:0], 1'b0};
            carry_o  = a_i[WIDTH-1];
         end
         OP_SHR1: begin
            result_o = {1'b0, a_i[WIDTH-1:1]};
            carry_o  = a_i[0];
         end
         OP_PASS: result_o = a_i;
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_lockstep_checker.sv
// Dual-lane ALU with registered result stage, lane comparator, saturating
// mismatch counter and sticky fault with one-shot interrupt.
module alu_lockstep_checker
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned FAULT_THRESH = 1
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic [OP_W-1:0]  sel0,
   input  logic [OP_W-1:0]  sel1,
   input  logic             lockstep_i,
   input  logic             inject_i,
   input  logic             clear_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out0,
   output logic [WIDTH-1:0] alu_out1,
   output logic             carry0,
   output logic             carry1,
   output logic [WIDTH-1:0] x,
   output logic             y,
   output logic             mismatch,
   output logic [CNT_W-1:0] mis_cnt,
   output logic             fault_o,
   output logic             irq_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAULT_THRESH);

   logic [WIDTH-1:0] l1_a, l1_b;
   logic [OP_W-1:0]  l1_sel;
   logic [WIDTH-1:0] r0, r1;
   logic             c0, c1;

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
   logic             cy0_q, cy0_d, cy1_q, cy1_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_q, fault_d;
   logic             irq_q, irq_d;

   logic             accept;
   logic             deliver_mis;

   // Lane 1 operand select: own operands, or lane 0 duplicated for lockstep.
   always_comb begin
      l1_a   = lockstep_i ? a0   : a1;
      l1_b   = lockstep_i ? b0   : b1;
      l1_sel = lockstep_i ? sel0 : sel1;
   end

   alu_lane #(.WIDTH(WIDTH)) u_lane0 (
      .a_i(a0), .b_i(b0), .sel_i(sel0), .result_o(r0), .carry_o(c0)
   );

   alu_lane #(.WIDTH(WIDTH)) u_lane1 (
      .a_i(l1_a), .b_i(l1_b), .sel_i(l1_sel), .result_o(r1), .carry_o(c1)
   );

   assign in_ready    = ~valid_q | out_ready;
   assign accept      = in_valid & in_ready;
   assign x           = res0_q ^ res1_q;
   assign y           = cy0_q ^ cy1_q;
   assign mismatch    = valid_q & ((|x) | y);
   assign deliver_mis = mismatch & out_ready;

   // Output stage: load on accept (even while draining), otherwise hold until consumed.
   always_comb begin
      valid_d = valid_q;
      res0_d  = res0_q;
      res1_d  = res1_q;
      cy0_d   = cy0_q;
      cy1_d   = cy1_q;
      if (accept) begin
         valid_d = 1'b1;
         res0_d  = r0;
         res1_d  = r1 ^ {{(WIDTH-1){1'b0}}, inject_i};
         cy0_d   = c0;
         cy1_d   = c1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Counter, sticky fault and rising-edge irq; clear overrides a same-cycle increment.
   always_comb begin
      cnt_d   = cnt_q;
      fault_d = fault_q;
      irq_d   = 1'b0;
      if (clear_i) begin
         cnt_d   = '0;
         fault_d = 1'b0;
      end else begin
         if (deliver_mis && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (cnt_d >= THRESH) begin
            fault_d = 1'b1;
         end
         irq_d = fault_d & ~fault_q;
      end
   end

   // State registers, asynchronously cleared.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         valid_q <= 1'b0;
         res0_q  <= '0;
         res1_q  <= '0;
         cy0_q   <= 1'b0;
         cy1_q   <= 1'b0;
         cnt_q   <= '0;
         fault_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         res0_q  <= res0_d;
         res1_q  <= res1_d;
         cy0_q   <= cy0_d;
         cy1_q   <= cy1_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
         irq_q   <= irq_d;
      end
   end

   assign out_valid = valid_q;
   assign alu_out0  = res0_q;
   assign alu_out1  = res1_q;
   assign carry0    = cy0_q;
   assign carry1    = cy1_q;
   assign mis_cnt   = cnt_q;
   assign fault_o   = fault_q;
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_alu_lockstep_checker.sv
// Bench for alu_lockstep_checker: directed scenarios plus a randomized run
// against an arithmetic reference model. Two instances share the stimulus:
// a default one (CNT_W=8, threshold 1) and a small one (CNT_W=2, threshold 2).
module tb_alu_lockstep_checker;

   localparam int W = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic [2:0] sel0 = '0, sel1 = '0;
   logic       lockstep = 1'b0, inject = 1'b0, clear = 1'b0;
   logic       out_ready = 1'b1;

   logic       in_ready, out_valid, carry0, carry1, y, mismatch, fault, irq;
   logic [3:0] alu_out0, alu_out1, x;
   logic [7:0] mis_cnt;

   logic       in_ready_s, out_valid_s, carry0_s, carry1_s, y_s, mismatch_s, fault_s, irq_s;
   logic [3:0] alu_out0_s, alu_out1_s, x_s;
   logic [1:0] mis_cnt_s;

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit mv;
   int mr0, mr1, mc0, mc1;
   int mcnt[2];
   bit mfault[2];
   bit mirq[2];
   int cmax[2] = '{255, 3};
   int thr[2]  = '{1, 2};

   always #5 clk = ~clk;

   alu_lockstep_checker #(.WIDTH(4), .CNT_W(8), .FAULT_THRESH(1)) dut (
      .wb_clk_i(clk), .wb_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel0(sel0), .sel1(sel1),
      .lockstep_i(lockstep), .inject_i(inject), .clear_i(clear),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_out0(alu_out0), .alu_out1(alu_out1), .carry0(carry0), .carry1(carry1),
      .x(x), .y(y), .mismatch(mismatch), .mis_cnt(mis_cnt), .fault_o(fault), .irq_o(irq)
   );

   alu_lockstep_checker #(.WIDTH(4), .CNT_W(2), .FAULT_THRESH(2)) dut_s (
      .wb_clk_i(clk), .wb_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel0(sel0), .sel1(sel1),
      .lockstep_i(lockstep), .inject_i(inject), .clear_i(clear),
      .out_valid(out_valid_s), .out_ready(out_ready),
      .alu_out0(alu_out0_s), .alu_out1(alu_out1_s), .carry0(carry0_s), .carry1(carry1_s),
      .x(x_s), .y(y_s), .mismatch(mismatch_s), .mis_cnt(mis_cnt_s), .fault_o(fault_s), .irq_o(irq_s)
   );

   // Returns carry*16 + result for a 4-bit ALU, from plain integer arithmetic.
   function automatic int alu_ref(input int a, input int b, input int sel);
      int s, r, c;
      r = 0;
      c = 0;
      case (sel)
         0: begin s = a + b; r = s % 16; c = s / 16; end
         1: begin s = a - b; c = (s < 0) ? 1 : 0; r = (s + 16) % 16; end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: begin r = (a * 2) % 16; c = a / 8; end
         6: begin r = a / 2; c = a % 2; end
         default: r = a;
      endcase
      return c * 16 + r;
   endfunction

   task automatic model_reset();
      mv = 0; mr0 = 0; mr1 = 0; mc0 = 0; mc1 = 0;
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0; mfault[k] = 0; mirq[k] = 0;
      end
   endtask

   // Advance the model by one clock using the inputs presently applied.
   task automatic model_edge();
      bit rdy, dm;
      int v0, v1;
      rdy = !mv || out_ready;
      dm  = mv && out_ready && ((mr0 != mr1) || (mc0 != mc1));
      for (int k = 0; k < 2; k++) begin
         if (clear) begin
            mcnt[k] = 0; mfault[k] = 0; mirq[k] = 0;
         end else begin
            if (dm && mcnt[k] < cmax[k]) mcnt[k]++;
            mirq[k] = !mfault[k] && (mcnt[k] >= thr[k]);
            if (mcnt[k] >= thr[k]) mfault[k] = 1;
         end
      end
      if (in_valid && rdy) begin
         v0 = alu_ref(int'(a0), int'(b0), int'(sel0));
         if (lockstep) v1 = alu_ref(int'(a0), int'(b0), int'(sel0));
         else          v1 = alu_ref(int'(a1), int'(b1), int'(sel1));
         mr0 = v0 % 16; mc0 = v0 / 16;
         mr1 = (v1 % 16) ^ int'(inject); mc1 = v1 / 16;
         mv = 1;
      end else if (out_ready) begin
         mv = 0;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      checks++; if ({mis_cnt, fault, irq, alu_out0, alu_out1, x, mismatch} !== '0) begin
         errors++; $display("FAIL rst_regs got cnt=%0d fault=%b irq=%b out0=%h out1=%h", mis_cnt, fault, irq, alu_out0, alu_out1); end
      checks++; if ({mis_cnt_s, fault_s, irq_s, out_valid_s} !== '0) begin
         errors++; $display("FAIL rst_small got cnt=%0d fault=%b irq=%b v=%b", mis_cnt_s, fault_s, irq_s, out_valid_s); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_lockstep_add();
      in_valid = 1; lockstep = 1; a0 = 4'd9; b0 = 4'd8; sel0 = 3'd0; inject = 0; out_ready = 1;
      tick();
      checks++; if ({alu_out0, alu_out1} !== 8'h11) begin errors++; $display("FAIL add_result got=%h/%h exp=1/1", alu_out0, alu_out1); end
      checks++; if ({carry0, carry1} !== 2'b11) begin errors++; $display("FAIL add_carry got=%b%b exp=11", carry0, carry1); end
      checks++; if ({x, mismatch, out_valid} !== 6'b000001) begin errors++; $display("FAIL add_cmp got x=%h mis=%b v=%b exp x=0 mis=0 v=1", x, mismatch, out_valid); end
      in_valid = 0;
      tick();
   endtask

   task automatic test_inject_sub();
      in_valid = 1; lockstep = 1; a0 = 4'd3; b0 = 4'd5; sel0 = 3'd1; inject = 1;
      tick();
      checks++; if (alu_out0 !== 4'd14 || alu_out1 !== 4'd15) begin errors++; $display("FAIL sub_result got=%0d/%0d exp=14/15", alu_out0, alu_out1); end
      checks++; if (x !== 4'b0001 || carry0 !== 1'b1 || mismatch !== 1'b1) begin
         errors++; $display("FAIL sub_cmp got x=%b borrow=%b mis=%b exp 0001/1/1", x, carry0, mismatch); end
      checks++; if (mis_cnt !== 8'd0) begin errors++; $display("FAIL sub_cnt_early got=%0d exp=0", mis_cnt); end
      in_valid = 0; inject = 0;
      tick();
      checks++; if (mis_cnt !== 8'd1 || fault !== 1'b1 || irq !== 1'b1) begin
         errors++; $display("FAIL sub_fault got cnt=%0d fault=%b irq=%b exp 1/1/1", mis_cnt, fault, irq); end
      checks++; if (mis_cnt_s !== 2'd1 || fault_s !== 1'b0) begin
         errors++; $display("FAIL sub_small got cnt=%0d fault=%b exp 1/0", mis_cnt_s, fault_s); end
      tick();
      checks++; if (irq !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL sub_irq_once got irq=%b fault=%b exp 0/1", irq, fault); end
   endtask

   task automatic test_backpressure();
      clear = 1; tick(); clear = 0;
      checks++; if (mis_cnt !== 8'd0 || fault !== 1'b0) begin errors++; $display("FAIL bp_clear got cnt=%0d fault=%b exp 0/0", mis_cnt, fault); end
      in_valid = 1; lockstep = 1; a0 = 4'd6; b0 = 4'd3; sel0 = 3'd3; inject = 1; out_ready = 0;
      tick();
      a0 = 4'd1; b0 = 4'd1; sel0 = 3'd0; inject = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_hs[%0d] got rdy=%b v=%b exp 0/1", i, in_ready, out_valid); end
         checks++; if (alu_out0 !== 4'd7 || alu_out1 !== 4'd6 || mis_cnt !== 8'd0) begin
            errors++; $display("FAIL bp_hold_data[%0d] got %0d/%0d cnt=%0d exp 7/6 cnt=0", i, alu_out0, alu_out1, mis_cnt); end
      end
      out_ready = 1;
      tick();
      checks++; if (out_valid !== 1'b1 || alu_out0 !== 4'd2 || alu_out1 !== 4'd2) begin
         errors++; $display("FAIL bp_no_bubble got v=%b %0d/%0d exp 1 2/2", out_valid, alu_out0, alu_out1); end
      checks++; if (mis_cnt !== 8'd1) begin errors++; $display("FAIL bp_cnt got=%0d exp=1", mis_cnt); end
      in_valid = 0;
      tick();
      checks++; if (out_valid !== 1'b0 || mis_cnt !== 8'd1) begin errors++; $display("FAIL bp_drain got v=%b cnt=%0d exp 0/1", out_valid, mis_cnt); end
   endtask

   task automatic test_saturation();
      int exp_cnt[5] = '{1, 2, 3, 3, 3};
      int irqs = 0;
      clear = 1; tick(); clear = 0;
      in_valid = 1; lockstep = 1; a0 = 4'd5; b0 = 4'd2; sel0 = 3'd2; inject = 1; out_ready = 1;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         if (irq_s === 1'b1) irqs++;
         checks++; if (mis_cnt_s !== 2'(exp_cnt[i])) begin errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, mis_cnt_s, exp_cnt[i]); end
      end
      in_valid = 0; inject = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (irq_s === 1'b1) irqs++;
      end
      checks++; if (fault_s !== 1'b1 || mis_cnt_s !== 2'd3) begin errors++; $display("FAIL sat_fault got fault=%b cnt=%0d exp 1/3", fault_s, mis_cnt_s); end
      checks++; if (irqs !== 1) begin errors++; $display("FAIL sat_irq_count got=%0d exp=1", irqs); end
      checks++; if (mis_cnt !== 8'd6) begin errors++; $display("FAIL sat_wide_cnt got=%0d exp=6", mis_cnt); end
   endtask

   task automatic test_clear();
      in_valid = 1; inject = 1; out_ready = 1;
      tick();
      in_valid = 0; inject = 0; clear = 1;
      tick();
      checks++; if (mis_cnt !== 8'd0 || fault !== 1'b0 || irq !== 1'b0) begin
         errors++; $display("FAIL clr_wide got cnt=%0d fault=%b irq=%b exp 0/0/0", mis_cnt, fault, irq); end
      checks++; if (mis_cnt_s !== 2'd0 || fault_s !== 1'b0 || irq_s !== 1'b0) begin
         errors++; $display("FAIL clr_small got cnt=%0d fault=%b irq=%b exp 0/0/0", mis_cnt_s, fault_s, irq_s); end
      clear = 0; in_valid = 1; inject = 1;
      tick();
      in_valid = 0; inject = 0;
      tick();
      checks++; if (mis_cnt !== 8'd1 || fault !== 1'b1 || irq !== 1'b1) begin
         errors++; $display("FAIL clr_refire got cnt=%0d fault=%b irq=%b exp 1/1/1", mis_cnt, fault, irq); end
      tick();
   endtask

   task automatic test_async_reset();
      lockstep = 0; a0 = 4'd3; b0 = 4'd5; sel0 = 3'd0; a1 = 4'd3; b1 = 4'd5; sel1 = 3'd4;
      in_valid = 1; out_ready = 0;
      tick();
      checks++; if (alu_out0 !== 4'd8 || alu_out1 !== 4'd6 || x !== 4'd14 || mismatch !== 1'b1) begin
         errors++; $display("FAIL indep_lanes got %0d/%0d x=%0d mis=%b exp 8/6 x=14 mis=1", alu_out0, alu_out1, x, mismatch); end
      in_valid = 0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || mis_cnt !== 8'd0 || fault !== 1'b0) begin
         errors++; $display("FAIL async_rst got v=%b cnt=%0d fault=%b exp 0/0/0", out_valid, mis_cnt, fault); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_rdy got=%b exp=1", in_ready); end
      model_reset();
      #1 rst_n = 1'b1;
      out_ready = 1; in_valid = 1;
      tick();
      in_valid = 0;
      tick();
      checks++; if (mis_cnt !== 8'd1 || fault !== 1'b1 || irq !== 1'b1) begin
         errors++; $display("FAIL indep_counted got cnt=%0d fault=%b irq=%b exp 1/1/1", mis_cnt, fault, irq); end
   endtask

   task automatic test_random();
      logic [16:0] obs, expv;
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         lockstep  = $urandom_range(0, 1) == 1;
         a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
         sel0 = 3'($urandom); sel1 = 3'($urandom);
         inject = ($urandom_range(0, 5) == 0);
         clear  = ($urandom_range(0, 40) == 0);
         tick();
         expv = {mv, !mv || out_ready, 4'(mr0), 4'(mr1), 1'(mc0), 1'(mc1), 4'(mr0 ^ mr1), 1'(mc0 ^ mc1),
                 mv && ((mr0 != mr1) || (mc0 != mc1))};
         obs  = {out_valid, in_ready, alu_out0, alu_out1, carry0, carry1, x, y, mismatch};
         checks++; if (obs !== expv) begin errors++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, obs, expv); end
         obs  = {out_valid_s, in_ready_s, alu_out0_s, alu_out1_s, carry0_s, carry1_s, x_s, y_s, mismatch_s};
         checks++; if (obs !== expv) begin errors++; $display("FAIL rnd_data_s[%0d] got=%h exp=%h", i, obs, expv); end
         checks++; if (mis_cnt !== 8'(mcnt[0]) || fault !== mfault[0] || irq !== mirq[0]) begin
            errors++; $display("FAIL rnd_cnt[%0d] got cnt=%0d f=%b i=%b exp %0d/%b/%b", i, mis_cnt, fault, irq, mcnt[0], mfault[0], mirq[0]); end
         checks++; if (mis_cnt_s !== 2'(mcnt[1]) || fault_s !== mfault[1] || irq_s !== mirq[1]) begin
            errors++; $display("FAIL rnd_cnt_s[%0d] got cnt=%0d f=%b i=%b exp %0d/%b/%b", i, mis_cnt_s, fault_s, irq_s, mcnt[1], mfault[1], mirq[1]); end
      end
      clear = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_lockstep_add();
      test_inject_sub();
      test_backpressure();
      test_saturation();
      test_clear();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
